// File: rtl/run_detector_pkg.sv
// Shared encodings for the run detector: FSM state codes, mode codes and
// the helper that decides whether a run value is eligible to match.
package run_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_MATCH = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONES    = 2'b00,
    MODE_ZEROS   = 2'b01,
    MODE_ANY     = 2'b10,
    MODE_ANY_ALT = 2'b11
  } mode_e;

  // Both 1x codes enable either run value.
  function automatic logic bit_enabled(input logic [1:0] mode, input logic b);
    logic en;
    en = 1'b0;
    if (mode[1])
      en = 1'b1;
    else if (mode == MODE_ZEROS)
      en = ~b;
    else
      en = b;
    return en;
  endfunction

endpackage

// File: rtl/run_detector_if.sv
// Sample/control inputs and status outputs of the run detector.
interface run_detector_if #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned RLW = $clog2(RUN_LEN + 1);

  logic             w;
  logic             in_valid;
  logic [1:0]       mode;
  logic             overlap;
  logic             clear;
  logic             z;
  logic [1:0]       state_o;
  logic [RLW-1:0]   run_len_o;
  logic [CNT_W-1:0] match_count;

  modport master (
    output w, in_valid, mode, overlap, clear,
    input  z, state_o, run_len_o, match_count
  );

  modport slave (
    input  w, in_valid, mode, overlap, clear,
    output z, state_o, run_len_o, match_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
// clr_i together with inc_i restarts the count at 1.
module sat_counter #(
  parameter int unsigned  W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = inc_i ? W'(1) : '0;
    else if (inc_i && (cnt_q != MAX))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_detector.sv
// Serial run detector: flags RUN_LEN consecutive equal accepted samples of
// the mode-enabled value, with optional overlapping detection.
module run_detector
  import run_detector_pkg::*;
#(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  run_detector_if.slave bus
);

  localparam int unsigned    RLW     = $clog2(RUN_LEN + 1);
  localparam logic [RLW-1:0] RUN_MAX = RLW'(RUN_LEN);

  state_e           state_q, state_d;
  logic             cur_bit_q, cur_bit_d;
  logic [RLW-1:0]   run_q, run_next;
  logic             run_clr, run_inc;
  logic [CNT_W-1:0] mc_q;
  logic             mc_clr, mc_inc;
  logic             same_bit;

  always_comb begin
    state_d   = state_q;
    cur_bit_d = cur_bit_q;
    run_clr   = 1'b0;
    run_inc   = 1'b0;
    mc_clr    = 1'b0;
    mc_inc    = 1'b0;
    run_next  = (run_q == RUN_MAX) ? run_q : run_q + RLW'(1);
    same_bit  = (state_q != ST_IDLE) && (bus.w == cur_bit_q);

    if (bus.clear) begin
      state_d   = ST_IDLE;
      cur_bit_d = 1'b0;
      run_clr   = 1'b1;
      mc_clr    = 1'b1;
    end else if (bus.in_valid) begin
      if (!same_bit) begin
        cur_bit_d = bus.w;
        run_clr   = 1'b1;
        run_inc   = 1'b1;
        state_d   = ST_RUN;
      end else if ((state_q == ST_MATCH) && !bus.overlap) begin
        // Non-overlapping: the matched run is consumed, this sample starts anew.
        run_clr = 1'b1;
        run_inc = 1'b1;
        state_d = ST_RUN;
      end else begin
        run_inc = 1'b1;
        if ((run_next == RUN_MAX) && bit_enabled(bus.mode, cur_bit_q)) begin
          state_d = ST_MATCH;
          mc_inc  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= ST_IDLE;
      cur_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_bit_q <= cur_bit_d;
    end
  end

  sat_counter #(
    .W   (RLW),
    .MAX (RUN_MAX)
  ) u_run_cnt (
    .clk   (Clock),
    .rst_n (Resetn),
    .clr_i (run_clr),
    .inc_i (run_inc),
    .cnt_o (run_q)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (Clock),
    .rst_n (Resetn),
    .clr_i (mc_clr),
    .inc_i (mc_inc),
    .cnt_o (mc_q)
  );

  assign bus.z           = (state_q == ST_MATCH);
  assign bus.state_o     = state_q;
  assign bus.run_len_o   = run_q;
  assign bus.match_count = mc_q;

endmodule

// File: tb/tb_run_detector.sv
// Scoreboard bench for run_detector: two instances (CNT_W=8 and CNT_W=2) share
// stimulus; a sample-history reference model predicts every cycle's outputs.
module tb_run_detector;

  localparam int unsigned L = 4;

  typedef struct {
    logic       z;
    logic [1:0] st;
    logic [2:0] rl;
    logic [7:0] mc;
    logic [1:0] mc2;
  } exp_t;

  logic clk;
  logic rst_n;

  run_detector_if #(.RUN_LEN(4), .CNT_W(8)) bus  ();
  run_detector_if #(.RUN_LEN(4), .CNT_W(2)) bus2 ();

  assign bus2.w        = bus.w;
  assign bus2.in_valid = bus.in_valid;
  assign bus2.mode     = bus.mode;
  assign bus2.overlap  = bus.overlap;
  assign bus2.clear    = bus.clear;

  run_detector #(.RUN_LEN(4), .CNT_W(8)) u_dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  run_detector #(.RUN_LEN(4), .CNT_W(2)) u_dut2 (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t pend_exp;
  bit   pend = 1'b0;
  bit   done = 1'b0;

  // Reference model: sample history reduced to the current run.
  bit have;
  bit cur;
  int cnt;
  bit matched;
  int mc8;
  int mc2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    have = 0; cur = 0; cnt = 0; matched = 0; mc8 = 0; mc2 = 0;
  endtask

  task automatic model_apply(input logic wv, input logic v, input logic [1:0] m,
                             input logic ov, input logic cl);
    if (cl) begin
      model_reset();
    end else if (v) begin
      if (!have || wv != cur) begin
        have = 1; cur = wv; cnt = 1; matched = 0;
      end else if (matched && !ov) begin
        cnt = 1; matched = 0;
      end else begin
        cnt = (cnt + 1 > L) ? L : cnt + 1;
        matched = (cnt == L) && (m[1] || (m == 2'b00 ? cur == 1'b1 : cur == 1'b0));
      end
      if (matched) begin
        if (mc8 < 255) mc8++;
        if (mc2 < 3)   mc2++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.z   = matched;
    e.st  = !have ? 2'd0 : (matched ? 2'd2 : 2'd1);
    e.rl  = 3'(cnt);
    e.mc  = 8'(mc8);
    e.mc2 = 2'(mc2);
    return e;
  endfunction

  task automatic step(input logic wv, input logic v, input logic [1:0] m,
                      input logic ov, input logic cl);
    @(posedge clk); #1;
    if (pend) exp_q.push_back(pend_exp);
    bus.w = wv; bus.in_valid = v; bus.mode = m; bus.overlap = ov; bus.clear = cl;
    model_apply(wv, v, m, ov, cl);
    pend_exp = model_out();
    pend = 1'b1;
  endtask

  task automatic seq(input logic [1:0] m, input logic ov, input int n, input logic [15:0] bits);
    for (int i = 0; i < n; i++) step(bits[i], 1'b1, m, ov, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, bus.mode, bus.overlap, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, bus.mode, bus.overlap, 1'b1);
  endtask

  // Reset between edges: outputs must drop before the next clock edge.
  task automatic pulse_reset();
    @(negedge clk); #1;
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    rst_n = 1'b0;
    model_reset();
    pend = 1'b0;
    #1;
    chk("rst_z",     bus.z,            1'b0);
    chk("rst_state", bus.state_o,      2'd0);
    chk("rst_runlen", bus.run_len_o,   3'd0);
    chk("rst_mc",    bus.match_count,  8'd0);
    chk("rst_mc2",   bus2.match_count, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: the DUT presents a new result every cycle; compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("z",           bus.z,            e.z);
        chk("state_o",     bus.state_o,      e.st);
        chk("run_len_o",   bus.run_len_o,    e.rl);
        chk("match_count", bus.match_count,  e.mc);
        chk("mc_w2",       bus2.match_count, e.mc2);
        chk("z_w2",        bus2.z,           e.z);
      end
    end
  end

  initial begin
    logic lastw;
    logic [1:0] m;
    logic ov;
    rst_n = 1'b0;
    bus.w = 1'b0; bus.in_valid = 1'b0; bus.mode = 2'b00; bus.overlap = 1'b0; bus.clear = 1'b0;
    model_reset();
    #2;
    chk("init_z",     bus.z,           1'b0);
    chk("init_state", bus.state_o,     2'd0);
    chk("init_mc",    bus.match_count, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Either-value runs with overlap: 0x5 then 1x4.
    seq(2'b10, 1'b1, 9, 16'b0000_0001_1110_0000);
    do_clear();
    // Non-overlapping ones: eight 1s.
    seq(2'b00, 1'b0, 8, 16'h00FF);
    do_clear();
    // Disabled value reaching RUN_LEN stays in RUN.
    seq(2'b00, 1'b0, 5, 16'h0000);
    do_clear();
    // Gaps in in_valid do not break a run; z holds across idle cycles.
    seq(2'b00, 1'b0, 2, 16'h0003);
    idle(3);
    seq(2'b00, 1'b0, 2, 16'h0003);
    idle(5);
    do_clear();
    // Overlapping ones: narrow counter saturates, then clear.
    seq(2'b00, 1'b1, 8, 16'h00FF);
    do_clear();
    idle(1);
    // Zeros mode with overlap, then a mode change mid-run.
    seq(2'b01, 1'b1, 6, 16'h0000);
    seq(2'b00, 1'b1, 2, 16'h0000);
    do_clear();
    // Reset while in MATCH discards the run.
    seq(2'b00, 1'b1, 4, 16'h000F);
    pulse_reset();
    seq(2'b00, 1'b1, 4, 16'h000F);
    idle(2);

    lastw = 1'b0; m = 2'b10; ov = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) m  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ov = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) lastw = ~lastw;
      if ($urandom_range(0, 399) == 0)
        pulse_reset();
      else
        step(lastw, ($urandom_range(0, 3) != 0), m, ov, ($urandom_range(0, 79) == 0));
    end

    @(posedge clk); #1;
    if (pend) exp_q.push_back(pend_exp);
    pend = 1'b0;
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
